sym_vn_lut_loader: RTL and testbench
====================================

# sym_vn_lut_loader

Write-side controller for the symmetric variable-node IB-LUT RAM. It accepts a stream of 4-bit LUT entries over a valid/ready handshake and packs them into bank-0/bank-1 pairs. It then drives the LUT write port (`lut_in_bank0`, `lut_in_bank1`, `page_write_addr`, `write_addr_offset`, `we`) page by page, loading one full 64-page LUT image per start request. It sits between the host/ROM LUT source and the VN LUT wrapper, on the `write_clk` domain.

## Interface
- `PAGE_NUM`, 64: pages per LUT image.
- `PAGE_ADDR_W`, 6: page address width, equal to log2(PAGE_NUM).
- `DATA_W`, 4: LUT entry width.

- `write_clk`  in  1  write-domain clock; all logic is rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle load request; sampled only in IDLE.
- `offset_sel`  in  1  address-offset half to load; latched on accepted `start`.
- `in_data`  in  DATA_W  LUT entry from the source.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `lut_in_bank0`  out  DATA_W  bank-0 write data.
- `lut_in_bank1`  out  DATA_W  bank-1 write data.
- `page_write_addr`  out  PAGE_ADDR_W  write page address.
- `write_addr_offset`  out  1  write address offset, equal to the latched `offset_sel`.
- `we`  out  1  write enable, one-cycle pulse per page.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse after the last page write.

## Operation
- **Word order.** Entry 2p goes to bank 0 of page p; entry 2p+1 goes to bank 1 of page p. p runs 0..PAGE_NUM-1, so one load is 2·PAGE_NUM = 128 entries.
- **States:** IDLE, LOAD0, LOAD1, LAST, DONE.
- **IDLE.** `in_ready`=0. When `start`=1: latch `offset_sel`, clear the page counter, go to LOAD0.
- **LOAD0.** `in_ready`=1. On handshake (`in_valid`&&`in_ready`), register `in_data` into a bank-0 holding register, then go to LOAD1.
- **LOAD1.** `in_ready`=1. On handshake:
  - register outputs: `lut_in_bank0` from the holding register, `lut_in_bank1` from `in_data`, `page_write_addr` from the counter;
  - set `we`=1 for the next cycle only;
  - increment the page counter;
  - next state is LOAD0 if the page was < PAGE_NUM-1, otherwise LAST.
- **Overlap.** The `we` pulse for page p overlaps LOAD0 of page p+1.
- **LAST.** `in_ready`=0; `we` is high for page 63. Go to DONE.
- **DONE.** `done`=1 for one cycle, then go to IDLE.
- **`busy`** is 1 in LOAD0, LOAD1 and LAST, and 0 in IDLE and DONE.
- **Stalls.** With no handshake (`in_valid`=0), the state holds and no write is issued.
- **Output hold.** Write data, address and offset hold their last values between `we` pulses. The RAM samples them only while `we`=1.
- **Page counter.** PAGE_ADDR_W+1 bits wide; it is not allowed to wrap during a load. After DONE, `page_write_addr` stays at 63.
- **`start` while not in IDLE** is ignored, with no restart and no effect on the latched offset.
- **Reset mid-load.** Return to IDLE immediately and clear every output. RAM pages already written keep their contents; the unwritten pages are undefined. The source must restart its stream from entry 0.

## Timing
- **Reset values:** `in_ready`=0, `we`=0, `busy`=0, `done`=0, `lut_in_bank0`=0, `lut_in_bank1`=0, `page_write_addr`=0, `write_addr_offset`=0.
- **`in_ready` is a state decode only.** It never depends combinationally on `in_valid`.
- **Write latency:** `we` rises one cycle after the bank-1 handshake of that page.
- **Continuous `in_valid` case,** taking `start` high in cycle 0:
  - handshakes occur in cycles 1..128;
  - `we` for page p is in cycle 2p+3;
  - the last `we` is in cycle 129 (LAST);
  - `done` is in cycle 130;
  - IDLE is reached in cycle 131.
- **Throughput:** 2 cycles per page, one entry per cycle.
- **Back-to-back loads:** a `start` in the cycle after `done` (IDLE) is accepted.

## Structure
- Shared package `sym_vn_lut_pkg` holds:
  - the PAGE_NUM, PAGE_ADDR_W and DATA_W constants, shared with the read-side wrapper;
  - the state enum (IDLE/LOAD0/LOAD1/LAST/DONE).
- Single module. The FSM, page counter, holding register and output registers all live in one block; no sub-module is warranted.

## Test plan
- **Full load.** `offset_sel`=1, `in_valid` held high, `in_data`=k mod 16 for entry k.
  - Exactly 64 `we` pulses, in cycles 3, 5, …, 129.
  - Page p has bank0=(2p)%16 and bank1=(2p+1)%16.
  - `write_addr_offset`=1 on every write; `done` in cycle 130.
- **Back-pressure gaps.** Drop `in_valid` for 3 cycles after every 5th entry.
  - Same RAM image as the full load.
  - No `we` during gaps; `done` 3·25 cycles later than in the full load.
- **`start` re-pulsed mid-load.** Pulse `start` at page 10 with `offset_sel` toggled.
  - The load continues unaffected, with the offset unchanged.
  - `done` appears exactly once.
- **Reset mid-load.** Assert `rstn`=0 during LOAD1 of page 20.
  - All outputs are 0 in the same cycle; no further `we`.
  - A new `start` loads from page 0 correctly.
- **Integration readback.** Load with `offset_sel`=0, then read through the VN LUT wrapper at the chosen (y0,y1) points.
  - `t_c` matches the loaded image 2 read cycles later.

Source files
------------

// File: rtl/sym_vn_lut_pkg.sv
// Constants and state encoding for the symmetric VN IB-LUT RAM,
// shared by the write-side loader and the read-side wrapper.
package sym_vn_lut_pkg;

    localparam int PAGE_NUM    = 64;
    localparam int PAGE_ADDR_W = 6;
    localparam int DATA_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD0,
        ST_LOAD1,
        ST_LAST,
        ST_DONE
    } load_state_t;

endpackage

// File: rtl/sym_vn_lut_loader.sv
// Write-side loader: packs a stream of LUT entries into bank-0/bank-1 pairs
// and writes one full LUT image page by page into the VN LUT RAM.
module sym_vn_lut_loader
    import sym_vn_lut_pkg::*;
#(
    parameter int PAGE_NUM    = sym_vn_lut_pkg::PAGE_NUM,
    parameter int PAGE_ADDR_W = sym_vn_lut_pkg::PAGE_ADDR_W,
    parameter int DATA_W      = sym_vn_lut_pkg::DATA_W
) (
    input  logic                   write_clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   offset_sel,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      lut_in_bank0,
    output logic [DATA_W-1:0]      lut_in_bank1,
    output logic [PAGE_ADDR_W-1:0] page_write_addr,
    output logic                   write_addr_offset,
    output logic                   we,
    output logic                   busy,
    output logic                   done
);

    localparam logic [PAGE_ADDR_W:0] LAST_PAGE = (PAGE_ADDR_W+1)'(PAGE_NUM - 1);

    load_state_t              state;
    logic [PAGE_ADDR_W:0]     page_cnt;
    logic [DATA_W-1:0]        bank0_hold;
    logic                     handshake;

    assign handshake = in_valid && in_ready;

    // in_ready and busy are registered decodes of the state being entered,
    // so neither ever depends combinationally on in_valid.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state             <= ST_IDLE;
            page_cnt          <= '0;
            bank0_hold        <= '0;
            in_ready          <= 1'b0;
            lut_in_bank0      <= '0;
            lut_in_bank1      <= '0;
            page_write_addr   <= '0;
            write_addr_offset <= 1'b0;
            we                <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        write_addr_offset <= offset_sel;
                        page_cnt          <= '0;
                        in_ready          <= 1'b1;
                        busy              <= 1'b1;
                        state             <= ST_LOAD0;
                    end
                end
                ST_LOAD0: begin
                    if (handshake) begin
                        bank0_hold <= in_data;
                        state      <= ST_LOAD1;
                    end
                end
                ST_LOAD1: begin
                    if (handshake) begin
                        lut_in_bank0    <= bank0_hold;
                        lut_in_bank1    <= in_data;
                        page_write_addr <= page_cnt[PAGE_ADDR_W-1:0];
                        we              <= 1'b1;
                        page_cnt        <= page_cnt + 1'b1;
                        if (page_cnt == LAST_PAGE) begin
                            in_ready <= 1'b0;
                            state    <= ST_LAST;
                        end else begin
                            state <= ST_LOAD0;
                        end
                    end
                end
                ST_LAST: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Self-checking bench for sym_vn_lut_loader: a stream-level reference model
// checked every cycle, plus literal expectations on timing and RAM image.
module tb_sym_vn_lut_loader;
    import sym_vn_lut_pkg::*;

    logic                   write_clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   start = 1'b0;
    logic                   offset_sel = 1'b0;
    logic [DATA_W-1:0]      in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [DATA_W-1:0]      lut_in_bank0;
    logic [DATA_W-1:0]      lut_in_bank1;
    logic [PAGE_ADDR_W-1:0] page_write_addr;
    logic                   write_addr_offset;
    logic                   we;
    logic                   busy;
    logic                   done;

    sym_vn_lut_loader dut (
        .write_clk         (write_clk),
        .rstn              (rstn),
        .start             (start),
        .offset_sel        (offset_sel),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .lut_in_bank0      (lut_in_bank0),
        .lut_in_bank1      (lut_in_bank1),
        .page_write_addr   (page_write_addr),
        .write_addr_offset (write_addr_offset),
        .we                (we),
        .busy              (busy),
        .done              (done)
    );

    always #5 write_clk = ~write_clk;

    int tests_run = 0;
    int failures  = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge write_clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks accepted entries of the stream and derives
    // what the write port must show on the following cycle.
    bit         m_idle = 1'b1;
    int         m_count = 0;
    int         m_tail = 0;
    logic       m_ready = 1'b0, m_busy = 1'b0, m_we = 1'b0, m_done = 1'b0, m_off = 1'b0;
    logic [3:0] m_b0 = '0, m_b1 = '0, m_first = '0;
    logic [5:0] m_addr = '0;

    // Monitor record of what the RAM would hold, per load.
    logic [7:0] ram [PAGE_NUM];
    int  we_cnt = 0, done_cnt = 0, first_we = -1, last_we = -1, done_cyc = -1, off_bad = 0;
    logic exp_off = 1'b0;

    always @(negedge write_clk) begin
        logic n_we, n_done;
        if (!rstn) begin
            m_idle = 1'b1; m_count = 0; m_tail = 0;
            m_ready = 0; m_busy = 0; m_we = 0; m_done = 0; m_off = 0;
            m_b0 = 0; m_b1 = 0; m_addr = 0;
        end
        check_output("in_ready", in_ready, m_ready);
        check_output("busy", busy, m_busy);
        check_output("we", we, m_we);
        check_output("done", done, m_done);
        check_output("bank0", lut_in_bank0, m_b0);
        check_output("bank1", lut_in_bank1, m_b1);
        check_output("page_addr", page_write_addr, m_addr);
        check_output("offset", write_addr_offset, m_off);

        if (rstn) begin
            if (we) begin
                we_cnt++;
                if (first_we < 0) first_we = cyc - start_cyc;
                last_we = cyc - start_cyc;
                ram[page_write_addr] = {lut_in_bank0, lut_in_bank1};
                if (write_addr_offset !== exp_off) off_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - start_cyc;
            end

            n_we = 1'b0;
            n_done = 1'b0;
            if (m_tail == 1) begin
                m_busy = 1'b0; n_done = 1'b1; m_tail = 2;
            end else if (m_tail == 2) begin
                m_idle = 1'b1; m_tail = 0;
            end
            if (m_idle && start && m_tail == 0 && !m_done) begin
                m_off = offset_sel; m_count = 0; m_idle = 1'b0;
                m_busy = 1'b1; m_ready = 1'b1;
            end else if (m_ready && in_valid) begin
                if (m_count % 2 == 0) begin
                    m_first = in_data;
                end else begin
                    m_b0 = m_first; m_b1 = in_data;
                    m_addr = 6'(m_count / 2); n_we = 1'b1;
                end
                m_count++;
                if (m_count == 2 * PAGE_NUM) begin
                    m_ready = 1'b0; m_tail = 1;
                end
            end
            m_we = n_we;
            m_done = n_done;
        end
    end

    // Drives one load from the current position (just after a rising edge).
    // restart_entry re-pulses start with the other offset; reset_entry pulls rstn.
    task automatic apply_stimulus(input logic off, input bit gaps,
                                  input int restart_entry, input int reset_entry);
        int k = 0, gap = 0, budget = 0, pre;
        bit hs, fired = 0;
        we_cnt = 0; done_cnt = 0; first_we = -1; last_we = -1; done_cyc = -1; off_bad = 0;
        exp_off = off;
        for (int p = 0; p < PAGE_NUM; p++) ram[p] = 'x;
        start = 1'b1; offset_sel = off; in_valid = 1'b0; start_cyc = cyc;
        @(posedge write_clk); #1;
        start = 1'b0;
        while (k < 2 * PAGE_NUM && budget < 1000) begin
            if (k == reset_entry) begin
                rstn = 1'b0; in_valid = 1'b0; start = 1'b0;
                #1;
                check_output("rst_in_ready", in_ready, 0);
                check_output("rst_we", we, 0);
                check_output("rst_busy", busy, 0);
                check_output("rst_done", done, 0);
                check_output("rst_bank0", lut_in_bank0, 0);
                check_output("rst_bank1", lut_in_bank1, 0);
                check_output("rst_addr", page_write_addr, 0);
                check_output("rst_offset", write_addr_offset, 0);
                pre = we_cnt;
                check_output("pages_before_reset", pre, 20);
                repeat (3) @(posedge write_clk);
                #1;
                check_output("no_we_after_reset", we_cnt, pre);
                rstn = 1'b1;
                return;
            end
            in_valid = (gap == 0);
            in_data  = DATA_W'(k % 16);
            if (k == restart_entry && !fired) begin
                start = 1'b1; offset_sel = ~off; fired = 1'b1;
            end else begin
                start = 1'b0; offset_sel = off;
            end
            @(negedge write_clk);
            hs = in_valid && in_ready;
            @(posedge write_clk); #1;
            budget++;
            if (hs) begin
                k++;
                if (gaps && k % 5 == 0) gap = 3;
            end else if (gap > 0) begin
                gap--;
            end
        end
        in_valid = 1'b0; start = 1'b0; offset_sel = off;
        check_output("stream_in_time", budget < 1000, 1);
        budget = 0;
        while (done_cnt == 0 && budget < 20) begin
            @(negedge write_clk);
            budget++;
        end
        check_output("done_seen", done_cnt != 0, 1);
        @(posedge write_clk); #1;
    endtask

    task automatic check_image(input string name);
        int bad = 0;
        logic [7:0] e;
        for (int p = 0; p < PAGE_NUM; p++) begin
            e[7:4] = 4'((2 * p) % 16);
            e[3:0] = 4'((2 * p + 1) % 16);
            if (ram[p] !== e) bad++;
        end
        check_output(name, bad, 0);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) @(posedge write_clk);
        #1 rstn = 1'b1;
        @(posedge write_clk); #1;

        // Full load, continuous valid, offset 1
        apply_stimulus(1'b1, 1'b0, -1, -1);
        check_output("full_we_count", we_cnt, 64);
        check_output("full_first_we", first_we, 3);
        check_output("full_last_we", last_we, 129);
        check_output("full_done_cyc", done_cyc, 130);
        check_output("full_done_once", done_cnt, 1);
        check_output("full_offset", off_bad, 0);
        check_output("full_page0", ram[0], 8'h01);
        check_output("full_page63", ram[63], 8'hEF);
        check_image("full_image");

        // Back-to-back start in the IDLE cycle after done, with gaps
        apply_stimulus(1'b1, 1'b1, -1, -1);
        check_output("gap_we_count", we_cnt, 64);
        check_output("gap_done_cyc", done_cyc, 205);
        check_image("gap_image");

        // start re-pulsed at page 10 with toggled offset
        repeat (2) @(posedge write_clk);
        #1;
        apply_stimulus(1'b1, 1'b0, 20, -1);
        check_output("restart_done_once", done_cnt, 1);
        check_output("restart_done_cyc", done_cyc, 130);
        check_output("restart_offset", off_bad, 0);
        check_image("restart_image");

        // Reset during LOAD1 of page 20, then a clean reload with offset 0
        apply_stimulus(1'b1, 1'b0, -1, 41);
        @(posedge write_clk); #1;
        apply_stimulus(1'b0, 1'b0, -1, -1);
        check_output("reload_we_count", we_cnt, 64);
        check_output("reload_done_cyc", done_cyc, 130);
        check_output("reload_offset", off_bad, 0);
        check_output("reload_page10", ram[10], 8'h45);
        check_image("reload_image");

        repeat (3) @(posedge write_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
